// File: rtl/mult8_pkg.sv
// Shared types, widths and the sign-extension helper for the sequential 8x8 signed multiplier.
package mult8_pkg;

  localparam int unsigned DATA_W = 8;
  localparam logic [3:0] ITER_COUNT = 4'd8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StAdd      = 3'd1,
    StShift    = 3'd2,
    StHold     = 3'd3,
    StAddShift = 3'd4
  } state_e;

  function automatic logic [DATA_W:0] sext9(input logic [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

endpackage

// File: rtl/mult8_seq_core_addsub9.sv
// 9-bit adder/subtractor; sub_i=1 adds the two's complement of b_i, carry-out is dropped.
module addsub9 (
  input  logic [8:0] a_i,
  input  logic [8:0] b_i,
  input  logic       sub_i,
  output logic [8:0] sum_o
);

  logic [8:0] b_eff;

  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    sum_o = a_i + b_eff + {8'd0, sub_i};
  end

endmodule

// File: rtl/mult8_seq_core.sv
// Sequential 8x8 signed multiplier: X/A/B registers plus the add/shift control FSM.
// Define MULT8_MERGED_STEP_EN to fold add and shift into one ADDSHIFT state (8-cycle latency).
module mult8_seq_core
  import mult8_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              ClearA_LoadB,
  input  logic [DATA_W-1:0] S,
  output logic [DATA_W-1:0] Aval,
  output logic [DATA_W-1:0] Bval,
  output logic              Xval,
  output logic              Busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              x_q, x_d;
  logic [3:0]        k_q, k_d;
  logic              run_q, run_d;

  logic [8:0]        sum;
  logic [8:0]        step;
  logic              last_iter;

  assign last_iter = (k_q == ITER_COUNT);

  // The final iteration weighs the multiplier's sign bit negatively, hence subtract.
  addsub9 u_addsub9 (
    .a_i  (sext9(a_q)),
    .b_i  (sext9(S)),
    .sub_i(last_iter),
    .sum_o(sum)
  );

  assign step = b_q[0] ? sum : {x_q, a_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    k_d     = k_q;
    run_d   = Run;

    case (state_q)
      StIdle: begin
        if (ClearA_LoadB) begin
          b_d = S;
          a_d = '0;
          x_d = 1'b0;
        end else if (Run && !run_q) begin
          a_d = '0;
          x_d = 1'b0;
          k_d = 4'd1;
`ifdef MULT8_MERGED_STEP_EN
          state_d = StAddShift;
`else
          state_d = StAdd;
`endif
        end
      end
      StAdd: begin
        if (b_q[0]) begin
          x_d = sum[8];
          a_d = sum[7:0];
        end
        state_d = StShift;
      end
      StShift: begin
        a_d = {x_q, a_q[DATA_W-1:1]};
        b_d = {a_q[0], b_q[DATA_W-1:1]};
        if (last_iter) begin
          state_d = StHold;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = StAdd;
        end
      end
      StAddShift: begin
        x_d = step[8];
        a_d = step[8:1];
        b_d = {step[0], b_q[DATA_W-1:1]};
        if (last_iter) begin
          state_d = StHold;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      StHold: begin
        if (!Run) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= 1'b0;
      k_q     <= 4'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      k_q     <= k_d;
      run_q   <= run_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Xval = x_q;
  assign Busy = (state_q != StIdle) && (state_q != StHold);

endmodule

// File: tb/tb_mult8_seq_core.sv
// Bench for mult8_seq_core: directed and random multiplications against a plain-arithmetic model.
module tb_mult8_seq_core;

  logic       clk = 1'b0;
  logic       reset, run, clr;
  logic [7:0] s, aval, bval;
  logic       xval, busy;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] b_model;

`ifdef MULT8_MERGED_STEP_EN
  localparam int Lat = 8;
`else
  localparam int Lat = 16;
`endif

  always #5 clk = ~clk;

  mult8_seq_core dut (
    .Clk         (clk),
    .Reset       (reset),
    .Run         (run),
    .ClearA_LoadB(clr),
    .S           (s),
    .Aval        (aval),
    .Bval        (bval),
    .Xval        (xval),
    .Busy        (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] bv);
    s   = bv;
    clr = 1'b1;
    step();
    clr = 1'b0;
    b_model = bv;
    check("load_b", 16'(bval), 16'(bv));
    check("load_a", 16'(aval), 16'h0000);
  endtask

  // Model: the product is simply the signed product of B and S; X is its sign.
  task automatic run_op(input logic [7:0] sv, input bit clr_mid, output logic [15:0] prod);
    logic signed [15:0] p;
    int n;
    s = sv;
    p = $signed({{8{b_model[7]}}, b_model}) * $signed({{8{sv[7]}}, sv});
    run = 1'b1;
    step();
    n = 0;
    while (busy && n < 40) begin
      clr = (clr_mid && n == 3);
      n++;
      step();
    end
    clr = 1'b0;
    check("busy_cycles", 16'(n), 16'(Lat));
    check("product", {aval, bval}, p);
    check("x_bit", 16'(xval), 16'(p[15]));
    b_model = p[7:0];
    step();
    step();
    check("hold_product", {aval, bval}, p);
    check("hold_busy", 16'(busy), 16'h0000);
    run = 1'b0;
    step();
    prod = p;
  endtask

  initial begin
    logic [15:0] prod;
    reset = 1'b1;
    run   = 1'b0;
    clr   = 1'b0;
    s     = 8'h00;
    b_model = 8'h00;
    step();
    step();
    reset = 1'b0;
    check("rst_a", 16'(aval), 16'h0000);
    check("rst_b", 16'(bval), 16'h0000);
    check("rst_x", 16'(xval), 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);

    // -3 * 7 = -21, then rerun on the previous low byte: 0xEB * 7 = -147
    load(8'hFD);
    run_op(8'h07, 1'b0, prod);
    check("ex_m21", {xval, aval, bval} & 16'hFFFF, 16'hFFEB);
    check("ex_m21_x", 16'(xval), 16'h0001);
    run_op(8'h07, 1'b0, prod);
    check("ex_m147", {aval, bval}, 16'hFF6D);

    load(8'hFE);
    run_op(8'hFE, 1'b0, prod);
    check("ex_4", {aval, bval}, 16'h0004);
    load(8'h80);
    run_op(8'h80, 1'b0, prod);
    check("ex_4000", {aval, bval}, 16'h4000);
    check("ex_4000_x", 16'(xval), 16'h0000);
    load(8'h00);
    run_op(8'h55, 1'b0, prod);
    check("ex_zero", {aval, bval}, 16'h0000);

    // A load request mid-operation must be ignored
    load(8'h33);
    run_op(8'hC5, 1'b1, prod);

    // Reset in the middle of an operation
    load(8'h12);
    s   = 8'h34;
    run = 1'b1;
    step();
    repeat (4) step();
    check("mid_busy", 16'(busy), 16'h0001);
    reset = 1'b1;
    step();
    check("abort_a", 16'(aval), 16'h0000);
    check("abort_b", 16'(bval), 16'h0000);
    check("abort_x", 16'(xval), 16'h0000);
    check("abort_busy", 16'(busy), 16'h0000);
    reset = 1'b0;
    run   = 1'b0;
    step();
    check("abort_idle", 16'(busy), 16'h0000);
    b_model = 8'h00;

    // Run and load together in IDLE: the load wins, nothing starts
    s   = 8'h9A;
    run = 1'b1;
    clr = 1'b1;
    step();
    check("both_busy", 16'(busy), 16'h0000);
    check("both_b", 16'(bval), 16'h009A);
    check("both_a", 16'(aval), 16'h0000);
    clr = 1'b0;
    step();
    check("both_no_start", 16'(busy), 16'h0000);
    run = 1'b0;
    step();
    b_model = 8'h9A;
    run_op(8'h03, 1'b0, prod);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(2) != 0) load(8'($urandom));
      run_op(8'($urandom), 1'b0, prod);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
